// File: rtl/block_loader.sv
// Byte-serial block loader: gathers 16 plaintext bytes and a key, launches the
// encryption core, watches it for a hang and holds the ciphertext until it is taken.
module block_loader #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic [7:0]   din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [127:0] core_plaintext,
  output logic [127:0] core_key,
  output logic         core_start,
  input  logic         core_ready,
  input  logic [127:0] core_ciphertext,
  output logic [127:0] ct_out,
  output logic         ct_valid,
  input  logic         ct_accept,
  output logic         busy,
  output logic         timeout_err
);

  // state  | meaning
  // FILL   | accepting plaintext bytes and key loads
  // START  | one-cycle start pulse to the core
  // WAIT   | core running, hang timer active
  // OUT    | ciphertext held until downstream accepts
  typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_OUT} state_e;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e         state_q, state_d;
  logic [3:0]     byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   ct_q, ct_d;
  logic           ct_valid_q, ct_valid_d;
  logic           timeout_q, timeout_d;
  logic           xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FILL;
      byte_cnt_q <= '0;
      wait_cnt_q <= '0;
      pt_q       <= '0;
      key_q      <= '0;
      ct_q       <= '0;
      ct_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      pt_q       <= pt_d;
      key_q      <= key_d;
      ct_q       <= ct_d;
      ct_valid_q <= ct_valid_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wait_cnt_d = wait_cnt_q;
    pt_d       = pt_q;
    key_d      = key_q;
    ct_d       = ct_q;
    ct_valid_d = ct_valid_q;
    timeout_d  = timeout_q;
    xfer       = din_valid && din_ready;
    case (state_q)
      S_FILL: begin
        if (key_load) begin
          key_d     = key_in;
          timeout_d = 1'b0;
        end
        if (xfer) begin
          // byte 0 lands in the most significant byte lane
          pt_d[7'd127 - {byte_cnt_q, 3'b000} -: 8] = din;
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd15) state_d = S_START;
        end
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_ready) begin
          ct_d       = core_ciphertext;
          ct_valid_d = 1'b1;
          state_d    = S_OUT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d  = 1'b1;
          byte_cnt_d = '0;
          ct_valid_d = 1'b0;
          state_d    = S_FILL;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (ct_accept) begin
          ct_valid_d = 1'b0;
          state_d    = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // din_ready is gated by rst so it is low for the whole reset pulse
  assign din_ready      = (state_q == S_FILL) && !rst;
  assign core_start     = (state_q == S_START);
  assign busy           = (state_q != S_FILL);
  assign core_plaintext = pt_q;
  assign core_key       = key_q;
  assign ct_out         = ct_q;
  assign ct_valid       = ct_valid_q;
  assign timeout_err    = timeout_q;

endmodule

// File: doc/block_loader.md
BLOCK_LOADER -- requirements
Module: block_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the maximum number of WAIT cycles before the core is declared hung.
REQ-002 SHALL have port clk  in  1  single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port key_in  in  128  cipher key to latch.
REQ-005 SHALL have port key_load  in  1  latch key_in when high in FILL.
REQ-006 SHALL have port din  in  8  plaintext byte.
REQ-007 SHALL have port din_valid  in  1  din is valid.
REQ-008 SHALL have port din_ready  out  1  loader accepts a byte this cycle.
REQ-009 SHALL have port core_plaintext  out  128  assembled block to the encryption core.
REQ-010 SHALL have port core_key  out  128  latched key to the encryption core.
REQ-011 SHALL have port core_start  out  1  one-cycle start pulse to the core.
REQ-012 SHALL have port core_ready  in  1  core completion pulse.
REQ-013 SHALL have port core_ciphertext  in  128  core result, valid when core_ready=1.
REQ-014 SHALL have port ct_out  out  128  captured ciphertext.
REQ-015 SHALL have port ct_valid  out  1  ct_out valid.
REQ-016 SHALL have port ct_accept  in  1  downstream takes ct_out.
REQ-017 SHALL have port busy  out  1  high in every state except FILL.
REQ-018 SHALL have port timeout_err  out  1  sticky core-hang flag.

Function
REQ-019 SHALL implement states FILL, START, WAIT, OUT.
REQ-020 FILL: din_ready=1; a byte transfers when din_valid && din_ready; 4-bit byte_cnt increments per transfer.
REQ-021 Byte order SHALL be big-endian: byte k (0..15) lands in core_plaintext[127-8k -: 8].
REQ-022 The transfer with byte_cnt=15 SHALL move the state to START next cycle and wrap byte_cnt to 0.
REQ-023 START: core_start=1 for exactly one cycle, then WAIT; din_ready=0 in START, WAIT and OUT.
REQ-024 core_plaintext and core_key SHALL be stable from START until leaving WAIT.
REQ-025 WAIT: on core_ready=1, capture core_ciphertext into ct_out, set ct_valid=1, go to OUT.
REQ-026 WAIT: a wait counter starts at 0 on entry; if it reaches TIMEOUT_CYCLES-1 with no core_ready, set timeout_err=1, clear byte_cnt, go to FILL with ct_valid=0.
REQ-027 core_ready outside WAIT SHALL be ignored.
REQ-028 OUT: ct_valid stays 1 and ct_out stable until ct_accept=1; on that cycle ct_valid clears next edge and the state returns to FILL.
REQ-029 key_load=1 in FILL SHALL latch key_in into core_key and clear timeout_err; key_load is ignored in other states.
REQ-030 key_load and a byte transfer in the same FILL cycle SHALL both take effect.
REQ-031 Latency: 16th byte accepted at edge N -> core_start high in cycle N+1; core_ready at edge M -> ct_valid high after edge M.
REQ-032 Throughput: no new byte is accepted until the previous block's ct_accept handshake completes.

Reset
REQ-033 rst=1 SHALL immediately force state=FILL, byte_cnt=0, wait counter=0.
REQ-034 rst=1 SHALL immediately force core_plaintext=0, core_key=0, ct_out=0, core_start=0, ct_valid=0, timeout_err=0, busy=0, din_ready=0.
REQ-035 After rst deasserts, din_ready=1 from the first clock edge.
REQ-036 rst in any state, including mid-WAIT, SHALL abandon the block; a core_ready arriving afterwards SHALL be ignored.

Verification
REQ-037 Load key 0x0f0e..00 (bytes 0x0f down to 0x00), stream bytes 0x00..0x0f with a core model returning plaintext XOR key after 20 cycles -> core_plaintext=0x000102..0f, one core_start pulse, ct_out=0x0f0f..0f (each byte 0x0f), ct_valid held until ct_accept.
REQ-038 din_valid toggled randomly during FILL -> exactly 16 transfers, correct byte order, core_start only after the 16th.
REQ-039 Core model never asserts core_ready, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 WAIT cycles, state FILL, din_ready=1; next key_load clears timeout_err.
REQ-040 ct_accept held low for 50 cycles -> ct_out stable, din_ready=0, busy=1 throughout; two back-to-back blocks are produced correctly once accepted.
REQ-041 rst pulsed mid-WAIT, then a late core_ready -> all outputs 0, ct_valid stays 0, next 16 bytes form a fresh block.
REQ-042 key_load asserted in WAIT with a new key -> core_key unchanged and the current result matches the old key.
